// File: rtl/gate_bank_pkg.sv
// Shared definitions for the gate bank self-test: output bit map, FSM encodings
// and the golden truth function used by both the tester and its testbench.
package gate_bank_pkg;

    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int XOR_B  = 2;
    localparam int XNOR_B = 3;
    localparam int NAND_B = 4;
    localparam int NOR_B  = 5;
    localparam int NOTA_B = 6;
    localparam int NOTB_B = 7;

    localparam int NUM_VEC = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // vec = {a,b}; a is the MSB
    function automatic logic [7:0] expect_vec(input logic [1:0] vec);
        logic a;
        logic b;
        logic [7:0] e;
        a = vec[1];
        b = vec[0];
        e         = '0;
        e[AND_B]  = a & b;
        e[OR_B]   = a | b;
        e[XOR_B]  = a ^ b;
        e[XNOR_B] = ~(a ^ b);
        e[NAND_B] = ~(a & b);
        e[NOR_B]  = ~(a | b);
        e[NOTA_B] = ~a;
        e[NOTB_B] = ~b;
        return e;
    endfunction

endpackage

// File: rtl/gate_bank_expect.sv
// Combinational golden model: expected gate bank outputs for a {a,b} vector.
module gate_bank_expect
    import gate_bank_pkg::*;
(
    input  logic [1:0] vec,
    output logic [7:0] expected
);

    assign expected = expect_vec(vec);

endmodule

// File: rtl/gate_bank_tester.sv
// Self-test sequencer: sweeps {ain,bin} through 00..11, holds each vector for
// SETTLE cycles, samples obs on the last edge and accumulates mismatch results.
//
// state   | meaning
// IDLE    | waiting for start; stimulus parked at 00, results held
// RUN     | sweeping vectors; sample on settle terminal count
// DONE    | one-cycle done pulse, pass valid; returns to IDLE
module gate_bank_tester
    import gate_bank_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] obs,
    output logic       ain,
    output logic       bin,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic [7:0] fail_cnt,
    output logic [1:0] first_fail,
    output logic       first_fail_vld
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [3:0] LAST_LOOP   = 4'(LOOPS - 1);

    state_t     state;
    logic [1:0] vec;
    logic [3:0] loop_cnt;
    logic [7:0] settle_cnt;
    logic [7:0] expected;
    logic [7:0] mm;

    gate_bank_expect u_expect (
        .vec      (vec),
        .expected (expected)
    );

    assign mm   = obs ^ expected;
    assign ain  = vec[1];
    assign bin  = vec[0];
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            vec            <= 2'd0;
            loop_cnt       <= 4'd0;
            settle_cnt     <= SETTLE_LOAD;
            pass           <= 1'b0;
            err_mask       <= 8'd0;
            fail_cnt       <= 8'd0;
            first_fail     <= 2'd0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    vec        <= 2'd0;
                    loop_cnt   <= 4'd0;
                    settle_cnt <= SETTLE_LOAD;
                    if (start) begin
                        state          <= ST_RUN;
                        pass           <= 1'b0;
                        err_mask       <= 8'd0;
                        fail_cnt       <= 8'd0;
                        first_fail     <= 2'd0;
                        first_fail_vld <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else begin
                        err_mask <= err_mask | mm;
                        if (mm != 8'd0) begin
                            if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                            if (!first_fail_vld) begin
                                first_fail     <= vec;
                                first_fail_vld <= 1'b1;
                            end
                        end
                        // wraps 11 -> 00, which also parks the stimulus for DONE
                        vec        <= vec + 2'd1;
                        settle_cnt <= SETTLE_LOAD;
                        if (vec == 2'(NUM_VEC - 1)) begin
                            if (loop_cnt == LAST_LOOP) begin
                                state <= ST_DONE;
                                pass  <= ((err_mask | mm) == 8'd0);
                            end else begin
                                loop_cnt <= loop_cnt + 4'd1;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
